serial_key_unlock: RTL and testbench
====================================

Name: serial_key_unlock

Overview:
- Parametrised serial unlock decoder for the binary calculator command path.
- Shifts a KEY_W-bit key followed by a MODE_W-bit mode field in one bit per valid command, then compares the key against KEY_VALUE.
- On a match, asserts Active, which enables the calculator. In the active state the mode can be updated serially.
- Adds behaviour beyond the first-generation decoder: failed-attempt counting, timed lockout, explicit relock and a multi-bit mode field.

Parameters:
- KEY_W, 4, key length in bits (>=1).
- MODE_W, 1, mode field length in bits (>=1).
- KEY_VALUE, 4'b1010, expected key, KEY_W bits, MSB received first.
- MAX_FAILS, 3, consecutive mismatches that trigger lockout (>=1).
- LOCK_CYCLES, 8, lockout duration in Clk cycles (>=1).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- ValidCmd  input  1  qualifies InputKey for the current cycle.
- InputKey  input  1  serial key/mode bit.
- Lock  input  1  relock request, honoured in ACTIVE only.
- Active  output  1  unlocked indicator (registered).
- Mode  output  MODE_W  current mode (registered).
- LockedOut  output  1  high while in LOCKOUT (registered).
- FailCnt  output  clog2(MAX_FAILS+1)  consecutive failed attempts (registered).

Behaviour:
- Reset:
  - Sampled on the rising Clk edge; overrides every other input.
  - State=SHIFT, bit counter=0, shift register=0, Active=0, Mode=0, LockedOut=0, FailCnt=0, lockout timer=0.
- Shift register: KEY_W+MODE_W bits; each accepted bit enters at the LSB, older bits move up.
- SHIFT:
  - Each cycle with ValidCmd=1 shifts InputKey in and increments the bit counter.
  - When the counter reaches KEY_W+MODE_W-1 and that bit is accepted, the next state is VERIFY.
  - Cycles with ValidCmd=0 hold all state.
  - Lock is ignored.
- VERIFY:
  - Lasts exactly one cycle, regardless of ValidCmd; InputKey is not sampled.
  - Match (upper KEY_W bits == KEY_VALUE): next state ACTIVE; Active=1; Mode=lower MODE_W bits; FailCnt=0.
  - Mismatch: shift register and counter cleared, FailCnt+1.
    - If the new FailCnt == MAX_FAILS: next state LOCKOUT, LockedOut=1, timer=LOCK_CYCLES-1.
    - Otherwise: next state SHIFT.
- Latency: Active rises on the clock edge one cycle after the edge that accepts the last bit.
- ACTIVE:
  - Lock=1: next state SHIFT; Active=0; Mode=0; shift register and counter cleared; FailCnt stays 0. Lock takes priority over ValidCmd in the same cycle.
  - Otherwise, ValidCmd=1: Mode <= {Mode[MODE_W-2:0], InputKey}. For MODE_W=1, Mode <= InputKey.
  - Active stays 1.
- LOCKOUT:
  - ValidCmd, InputKey and Lock are ignored.
  - The timer decrements every cycle. On the cycle the timer is 0, the next state is SHIFT with LockedOut=0 and FailCnt=0.
  - Total LockedOut high time is exactly LOCK_CYCLES cycles.
- Unreachable state encodings return to SHIFT with all registers cleared.
- Reset in the middle of shifting, VERIFY, ACTIVE or LOCKOUT gives the full reset values on the next edge. Partial keys are discarded.
- Comparison is a plain equality on the upper KEY_W bits of the shift register. Mode bits are excluded from the comparison.

Test Plan:
- Defaults; Reset, then ValidCmd bits 1,0,1,0,1 on consecutive cycles -> VERIFY on the next cycle; the following edge gives Active=1, Mode=1, FailCnt=0.
- Same sequence 1,0,1,0,0 with ValidCmd=0 gaps between bits -> the gaps hold state; Active=1, Mode=0.
- Three wrong keys 0000_0 -> FailCnt 1,2, then LockedOut=1 for exactly 8 cycles. ValidCmd pulses during lockout are ignored, then FailCnt=0. The correct key afterwards unlocks.
- Two wrong keys, then the correct key -> FailCnt goes 1,2, then 0 at unlock; LockedOut never rises.
- In ACTIVE: ValidCmd with InputKey=0 gives Mode=0. Then Lock=1 together with ValidCmd=1 -> Active=0, Mode=0, state SHIFT; the next 5 bits are treated as a new key.
- MODE_W=2, KEY_W=3, KEY_VALUE=3'b110: shift 1,1,0,1,0 -> Active=1, Mode=2'b10. Assert Reset after 2 bits of a new attempt -> all outputs 0.

Source files
------------

// File: rtl/serial_key_unlock.sv
// Serial unlock decoder for the calculator command path.
// A KEY_W-bit key followed by a MODE_W-bit mode field arrives one bit per
// valid command, MSB first. A matching key unlocks the calculator (Active)
// and loads the mode. Consecutive mismatches are counted, and reaching
// MAX_FAILS starts a timed lockout. Once unlocked, the mode can be updated
// serially. Lock relocks the decoder.
module serial_key_unlock #(
    parameter int                KEY_W       = 4,
    parameter int                MODE_W      = 1,
    parameter logic [KEY_W-1:0]  KEY_VALUE   = 4'b1010,
    parameter int                MAX_FAILS   = 3,
    parameter int                LOCK_CYCLES = 8
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             ValidCmd,
    input  logic                             InputKey,
    input  logic                             Lock,
    output logic                             Active,
    output logic [MODE_W-1:0]                Mode,
    output logic                             LockedOut,
    output logic [$clog2(MAX_FAILS+1)-1:0]   FailCnt
);

    localparam int SHIFT_W = KEY_W + MODE_W;
    localparam int CNT_W   = $clog2(SHIFT_W);
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int TMR_W   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_SHIFT   = 2'd0,
        S_VERIFY  = 2'd1,
        S_ACTIVE  = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [SHIFT_W-1:0]   shift_q,  shift_d;
    logic                 active_q, active_d;
    logic [MODE_W-1:0]    mode_q,   mode_d;
    logic                 locked_q, locked_d;
    logic [FAIL_W-1:0]    fail_q,   fail_d;
    logic [TMR_W-1:0]     timer_q,  timer_d;
    logic [FAIL_W-1:0]    fail_inc;

    // State register: synchronous reset to the idle SHIFT state with all fields cleared.
    always_ff @(posedge Clk) begin
        // NOTE: every register here is plain flop storage, so reset clears all of
        // them; the shift register must also be cleared so a partial key is discarded.
        if (Reset) begin
            state_q  <= S_SHIFT;
            cnt_q    <= '0;
            shift_q  <= '0;
            active_q <= 1'b0;
            mode_q   <= '0;
            locked_q <= 1'b0;
            fail_q   <= '0;
            timer_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop see pre-edge values,
            // which matches the hardware regardless of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            active_q <= active_d;
            mode_q   <= mode_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
            timer_q  <= timer_d;
        end
    end

    // Next-state logic: shift, verify, serial mode update and lockout timing.
    always_comb begin
        // NOTE: defaults first, so that every path assigns every signal and
        // no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        active_d = active_q;
        mode_d   = mode_q;
        locked_d = locked_q;
        fail_d   = fail_q;
        timer_d  = timer_q;
        fail_inc = fail_q + FAIL_W'(1);

        case (state_q)
            S_SHIFT: begin
                if (ValidCmd) begin
                    shift_d = {shift_q[SHIFT_W-2:0], InputKey};
                    if (cnt_q == CNT_W'(SHIFT_W - 1)) begin
                        cnt_d   = '0;
                        state_d = S_VERIFY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_VERIFY: begin
                // Only the key field is compared; the mode bits ride along.
                if (shift_q[SHIFT_W-1 -: KEY_W] == KEY_VALUE) begin
                    state_d  = S_ACTIVE;
                    active_d = 1'b1;
                    mode_d   = shift_q[MODE_W-1:0];
                    fail_d   = '0;
                end else begin
                    shift_d = '0;
                    cnt_d   = '0;
                    fail_d  = fail_inc;
                    if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                        state_d  = S_LOCKOUT;
                        locked_d = 1'b1;
                        timer_d  = TMR_W'(LOCK_CYCLES - 1);
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end

            S_ACTIVE: begin
                // Relock wins over a mode bit arriving in the same cycle.
                if (Lock) begin
                    state_d  = S_SHIFT;
                    active_d = 1'b0;
                    mode_d   = '0;
                    shift_d  = '0;
                    cnt_d    = '0;
                    fail_d   = '0;
                end else if (ValidCmd) begin
                    // Works for MODE_W == 1, where this reduces to Mode <= InputKey.
                    mode_d = (mode_q << 1) | MODE_W'(InputKey);
                end
            end

            S_LOCKOUT: begin
                // The timer starts at LOCK_CYCLES-1, so the exit happens on the
                // cycle it reads 0, and LockedOut is high for LOCK_CYCLES cycles.
                if (timer_q == '0) begin
                    state_d  = S_SHIFT;
                    locked_d = 1'b0;
                    fail_d   = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            default: begin
                state_d  = S_SHIFT;
                cnt_d    = '0;
                shift_d  = '0;
                active_d = 1'b0;
                mode_d   = '0;
                locked_d = 1'b0;
                fail_d   = '0;
                timer_d  = '0;
            end
        endcase
    end

    assign Active    = active_q;
    assign Mode      = mode_q;
    assign LockedOut = locked_q;
    assign FailCnt   = fail_q;

endmodule

// File: tb/tb_serial_key_unlock.sv
// Directed testbench for serial_key_unlock.
// dut1 uses the default parameters. dut2 uses KEY_W=3, MODE_W=2, KEY_VALUE=3'b110.
// Inputs are driven on the falling edge and outputs are sampled on the next falling edge.
module tb_serial_key_unlock;

    logic       clk;
    logic       reset1, valid1, key1, lock1;
    logic       active1, locked1;
    logic [0:0] mode1;
    logic [1:0] fail1;
    logic       reset2, valid2, key2, lock2;
    logic       active2, locked2;
    logic [1:0] mode2;
    logic [1:0] fail2;

    int n_checks = 0;
    int n_fail   = 0;

    serial_key_unlock dut1 (
        .Clk(clk), .Reset(reset1), .ValidCmd(valid1), .InputKey(key1), .Lock(lock1),
        .Active(active1), .Mode(mode1), .LockedOut(locked1), .FailCnt(fail1)
    );

    serial_key_unlock #(
        .KEY_W(3), .MODE_W(2), .KEY_VALUE(3'b110), .MAX_FAILS(3), .LOCK_CYCLES(8)
    ) dut2 (
        .Clk(clk), .Reset(reset2), .ValidCmd(valid2), .InputKey(key2), .Lock(lock2),
        .Active(active2), .Mode(mode2), .LockedOut(locked2), .FailCnt(fail2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick1(input logic v, input logic k, input logic l);
        valid1 = v; key1 = k; lock1 = l;
        @(negedge clk);
        valid1 = 1'b0; key1 = 1'b0; lock1 = 1'b0;
    endtask

    task automatic tick2(input logic v, input logic k, input logic l);
        valid2 = v; key2 = k; lock2 = l;
        @(negedge clk);
        valid2 = 1'b0; key2 = 1'b0; lock2 = 1'b0;
    endtask

    task automatic send_key1(input logic [4:0] bits, input bit gaps);
        for (int i = 4; i >= 0; i--) begin
            tick1(1'b1, bits[i], 1'b0);
            if (gaps && i > 0) tick1(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic send_key2(input logic [4:0] bits);
        for (int i = 4; i >= 0; i--) tick2(1'b1, bits[i], 1'b0);
    endtask

    task automatic test_reset;
        reset1 = 1'b1; reset2 = 1'b1;
        @(negedge clk); @(negedge clk);
        reset1 = 1'b0; reset2 = 1'b0;
        n_checks++; if (active1 !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", active1); end
        n_checks++; if (mode1 !== 1'b0) begin n_fail++; $display("FAIL reset_mode: got %b want 0", mode1); end
        n_checks++; if (locked1 !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked1); end
        n_checks++; if (fail1 !== 2'd0) begin n_fail++; $display("FAIL reset_failcnt: got %0d want 0", fail1); end
    endtask

    task automatic test_unlock_consecutive;
        send_key1(5'b10101, 1'b0);
        // The last bit has just been accepted, so the decoder is in VERIFY and not yet active.
        n_checks++; if (active1 !== 1'b0) begin n_fail++; $display("FAIL consec_verify_active: got %b want 0", active1); end
        tick1(1'b0, 1'b0, 1'b0);
        n_checks++; if (active1 !== 1'b1) begin n_fail++; $display("FAIL consec_active: got %b want 1", active1); end
        n_checks++; if (mode1 !== 1'b1) begin n_fail++; $display("FAIL consec_mode: got %b want 1", mode1); end
        n_checks++; if (fail1 !== 2'd0) begin n_fail++; $display("FAIL consec_failcnt: got %0d want 0", fail1); end
        tick1(1'b0, 1'b0, 1'b1);
        n_checks++; if (active1 !== 1'b0) begin n_fail++; $display("FAIL consec_relock: got %b want 0", active1); end
    endtask

    task automatic test_gaps_and_mode;
        send_key1(5'b10100, 1'b1);
        tick1(1'b0, 1'b0, 1'b0);
        n_checks++; if (active1 !== 1'b1) begin n_fail++; $display("FAIL gaps_active: got %b want 1", active1); end
        n_checks++; if (mode1 !== 1'b0) begin n_fail++; $display("FAIL gaps_mode: got %b want 0", mode1); end
        tick1(1'b1, 1'b1, 1'b0);
        n_checks++; if (mode1 !== 1'b1) begin n_fail++; $display("FAIL active_mode_set: got %b want 1", mode1); end
        tick1(1'b1, 1'b0, 1'b0);
        n_checks++; if (mode1 !== 1'b0) begin n_fail++; $display("FAIL active_mode_clr: got %b want 0", mode1); end
        tick1(1'b1, 1'b1, 1'b1);
        n_checks++; if (active1 !== 1'b0) begin n_fail++; $display("FAIL lock_prio_active: got %b want 0", active1); end
        n_checks++; if (mode1 !== 1'b0) begin n_fail++; $display("FAIL lock_prio_mode: got %b want 0", mode1); end
        // After the relock, the next five bits are treated as a fresh key.
        send_key1(5'b10101, 1'b0);
        tick1(1'b0, 1'b0, 1'b0);
        n_checks++; if (active1 !== 1'b1) begin n_fail++; $display("FAIL rekey_active: got %b want 1", active1); end
        n_checks++; if (mode1 !== 1'b1) begin n_fail++; $display("FAIL rekey_mode: got %b want 1", mode1); end
        tick1(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_lockout;
        int high_cycles;
        for (int a = 1; a <= 2; a++) begin
            send_key1(5'b00000, 1'b0);
            tick1(1'b0, 1'b0, 1'b0);
            n_checks++; if (fail1 !== 2'(a)) begin n_fail++; $display("FAIL lockout_failcnt%0d: got %0d want %0d", a, fail1, a); end
            n_checks++; if (locked1 !== 1'b0) begin n_fail++; $display("FAIL lockout_early%0d: got %b want 0", a, locked1); end
        end
        send_key1(5'b00000, 1'b0);
        tick1(1'b0, 1'b0, 1'b0);
        n_checks++; if (locked1 !== 1'b1) begin n_fail++; $display("FAIL lockout_enter: got %b want 1", locked1); end
        n_checks++; if (fail1 !== 2'd3) begin n_fail++; $display("FAIL lockout_failcnt3: got %0d want 3", fail1); end
        high_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (locked1 !== 1'b1) break;
            high_cycles++;
            tick1(1'b1, 1'b1, 1'b1);
        end
        n_checks++; if (high_cycles != 8) begin n_fail++; $display("FAIL lockout_duration: got %0d cycles want 8", high_cycles); end
        n_checks++; if (fail1 !== 2'd0) begin n_fail++; $display("FAIL lockout_exit_failcnt: got %0d want 0", fail1); end
        n_checks++; if (active1 !== 1'b0) begin n_fail++; $display("FAIL lockout_exit_active: got %b want 0", active1); end
        send_key1(5'b10101, 1'b0);
        tick1(1'b0, 1'b0, 1'b0);
        n_checks++; if (active1 !== 1'b1) begin n_fail++; $display("FAIL lockout_unlock: got %b want 1", active1); end
        tick1(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_two_fails_then_unlock;
        for (int a = 1; a <= 2; a++) begin
            send_key1(5'b11110, 1'b0);
            tick1(1'b0, 1'b0, 1'b0);
            n_checks++; if (fail1 !== 2'(a)) begin n_fail++; $display("FAIL two_fails_cnt%0d: got %0d want %0d", a, fail1, a); end
            n_checks++; if (locked1 !== 1'b0) begin n_fail++; $display("FAIL two_fails_locked%0d: got %b want 0", a, locked1); end
        end
        send_key1(5'b10100, 1'b0);
        tick1(1'b0, 1'b0, 1'b0);
        n_checks++; if (active1 !== 1'b1) begin n_fail++; $display("FAIL two_fails_active: got %b want 1", active1); end
        n_checks++; if (fail1 !== 2'd0) begin n_fail++; $display("FAIL two_fails_cleared: got %0d want 0", fail1); end
        n_checks++; if (locked1 !== 1'b0) begin n_fail++; $display("FAIL two_fails_nolock: got %b want 0", locked1); end
        tick1(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_mode_w2;
        send_key2(5'b11010);
        tick2(1'b0, 1'b0, 1'b0);
        n_checks++; if (active2 !== 1'b1) begin n_fail++; $display("FAIL w2_active: got %b want 1", active2); end
        n_checks++; if (mode2 !== 2'b10) begin n_fail++; $display("FAIL w2_mode: got %b want 10", mode2); end
        tick2(1'b1, 1'b1, 1'b0);
        n_checks++; if (mode2 !== 2'b01) begin n_fail++; $display("FAIL w2_mode_shift: got %b want 01", mode2); end
        tick2(1'b0, 1'b0, 1'b1);
        n_checks++; if (active2 !== 1'b0 || mode2 !== 2'b00) begin n_fail++; $display("FAIL w2_relock: got active %b mode %b want 0 00", active2, mode2); end
        send_key2(5'b01011);
        tick2(1'b0, 1'b0, 1'b0);
        n_checks++; if (fail2 !== 2'd1) begin n_fail++; $display("FAIL w2_failcnt: got %0d want 1", fail2); end
        tick2(1'b1, 1'b1, 1'b0);
        tick2(1'b1, 1'b1, 1'b0);
        reset2 = 1'b1;
        @(negedge clk);
        reset2 = 1'b0;
        n_checks++; if (active2 !== 1'b0 || mode2 !== 2'b00 || locked2 !== 1'b0 || fail2 !== 2'd0) begin
            n_fail++; $display("FAIL w2_mid_reset: got active %b mode %b locked %b fail %0d want all 0", active2, mode2, locked2, fail2);
        end
        // Any leftover partial bits would misalign this key.
        send_key2(5'b11001);
        tick2(1'b0, 1'b0, 1'b0);
        n_checks++; if (active2 !== 1'b1) begin n_fail++; $display("FAIL w2_after_reset_active: got %b want 1", active2); end
        n_checks++; if (mode2 !== 2'b01) begin n_fail++; $display("FAIL w2_after_reset_mode: got %b want 01", mode2); end
    endtask

    initial begin
        valid1 = 1'b0; key1 = 1'b0; lock1 = 1'b0; reset1 = 1'b1;
        valid2 = 1'b0; key2 = 1'b0; lock2 = 1'b0; reset2 = 1'b1;
        @(negedge clk);
        test_reset;
        test_unlock_consecutive;
        test_gaps_and_mode;
        test_lockout;
        test_two_fails_then_unlock;
        test_mode_w2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
